// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types and operand/forward select encodings for the core
package cpu_types_pkg;
   localparam int WORD_BITS = 32;
   localparam int REG_BITS  = 5;
   localparam int OP_BITS   = 4;
   typedef logic [WORD_BITS-1:0] word_t;
   typedef logic [REG_BITS-1:0]  regbits_t;
   typedef logic [OP_BITS-1:0]   aluop_t;
   // Encoding 3 of the A select is reserved and behaves like SRC_ZERO
   typedef enum logic [1:0] {SRC_RS1 = 2'd0, SRC_PC = 2'd1, SRC_ZERO = 2'd2} srcA_sel_t;
   typedef enum logic {SRC_RS2 = 1'b0, SRC_IMM = 1'b1} srcB_sel_t;
   typedef enum logic [1:0] {FWD_REG = 2'd0, FWD_EXMEM = 2'd1, FWD_MEMWB = 2'd2} fwd_sel_t;
endpackage

// File: rtl/forward_unit.sv
// forward_unit: priority compare choosing EX/MEM, then MEM/WB, then register data per source; x0 never matches
module forward_unit
   import cpu_types_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] rs1_i,
   input  logic [REG_ADDR_W-1:0] rs2_i,
   input  logic [REG_ADDR_W-1:0] exmem_rd_i,
   input  logic                  exmem_reg_write_i,
   input  logic [REG_ADDR_W-1:0] memwb_rd_i,
   input  logic                  memwb_reg_write_i,
   output fwd_sel_t              fwd_a_o,
   output fwd_sel_t              fwd_b_o
);
   logic ex_ok, wb_ok;
   assign ex_ok = exmem_reg_write_i && |exmem_rd_i;
   assign wb_ok = memwb_reg_write_i && |memwb_rd_i;
   // Youngest producer wins: EX/MEM over MEM/WB over the registered value
   always_comb begin
      fwd_a_o = (ex_ok && exmem_rd_i == rs1_i) ? FWD_EXMEM : (wb_ok && memwb_rd_i == rs1_i) ? FWD_MEMWB : FWD_REG;
      fwd_b_o = (ex_ok && exmem_rd_i == rs2_i) ? FWD_EXMEM : (wb_ok && memwb_rd_i == rs2_i) ? FWD_MEMWB : FWD_REG;
   end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand muxing, hazard stall and flush.
// ID_EX_FORWARD_EN: when defined, EX/MEM and MEM/WB forwarding plus hold refresh; otherwise
// operands come from registered data only and the stall widens to cover in-flight writers.
module id_ex_stage
   import cpu_types_pkg::*;
#(
   parameter int WORD_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int OP_W       = 4
) (
   input  logic                  clk,
   input  logic                  nRst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [REG_ADDR_W-1:0] in_rs1,
   input  logic [REG_ADDR_W-1:0] in_rs2,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic [WORD_W-1:0]     in_rs1_data,
   input  logic [WORD_W-1:0]     in_rs2_data,
   input  logic [WORD_W-1:0]     in_imm,
   input  logic [WORD_W-1:0]     in_pc,
   input  logic [OP_W-1:0]       in_alu_op,
   input  logic [1:0]            in_srcA_sel,
   input  logic                  in_srcB_sel,
   input  logic                  in_reg_write,
   input  logic                  in_mem_read,
   input  logic                  flush,
   input  logic                  ex_ready,
   input  logic [REG_ADDR_W-1:0] exmem_rd,
   input  logic                  exmem_reg_write,
   input  logic [WORD_W-1:0]     exmem_result,
   input  logic [REG_ADDR_W-1:0] memwb_rd,
   input  logic                  memwb_reg_write,
   input  logic [WORD_W-1:0]     memwb_result,
   output logic                  out_valid,
   output logic [WORD_W-1:0]     inputA,
   output logic [WORD_W-1:0]     inputB,
   output logic [OP_W-1:0]       ALUOp,
   output logic [REG_ADDR_W-1:0] out_rd,
   output logic                  out_reg_write,
   output logic                  out_mem_read,
   output logic [WORD_W-1:0]     out_store_data
);
   logic                  valid_q, valid_d;
   logic [REG_ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic [WORD_W-1:0]     rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
   logic [WORD_W-1:0]     imm_q, imm_d, pc_q, pc_d;
   logic [OP_W-1:0]       alu_op_q, alu_op_d;
   logic [1:0]            srcA_q, srcA_d;
   logic                  srcB_q, srcB_d;
   logic                  reg_write_q, reg_write_d, mem_read_q, mem_read_d;
   logic                  advance, hazard;
   logic [WORD_W-1:0]     rs1_fwd, rs2_fwd;
   assign advance       = !valid_q || ex_ready;
   assign in_ready      = !hazard && advance;
   assign out_valid     = valid_q;
   assign out_rd        = rd_q;
   assign ALUOp         = alu_op_q;
   assign out_reg_write = valid_q && reg_write_q;
   assign out_mem_read  = valid_q && mem_read_q;
`ifdef ID_EX_FORWARD_EN
   fwd_sel_t fwd_a, fwd_b;
   forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
      .rs1_i            (rs1_q),
      .rs2_i            (rs2_q),
      .exmem_rd_i       (exmem_rd),
      .exmem_reg_write_i(exmem_reg_write),
      .memwb_rd_i       (memwb_rd),
      .memwb_reg_write_i(memwb_reg_write),
      .fwd_a_o          (fwd_a),
      .fwd_b_o          (fwd_b)
   );
   assign rs1_fwd = fwd_a == FWD_EXMEM ? exmem_result : fwd_a == FWD_MEMWB ? memwb_result : rs1_data_q;
   assign rs2_fwd = fwd_b == FWD_EXMEM ? exmem_result : fwd_b == FWD_MEMWB ? memwb_result : rs2_data_q;
   // Only a load held here cannot be forwarded in time
   assign hazard  = out_mem_read && |rd_q && in_valid && (in_rs1 == rd_q || in_rs2 == rd_q);
`else
   logic dep1, dep2, unused_fwd;
   assign rs1_fwd    = rs1_data_q;
   assign rs2_fwd    = rs2_data_q;
   // Without forwarding any pending writer in EX or EX/MEM must drain; MEM/WB writes through the register file
   assign dep1       = |in_rs1 && ((out_reg_write && in_rs1 == rd_q) || (exmem_reg_write && in_rs1 == exmem_rd));
   assign dep2       = |in_rs2 && ((out_reg_write && in_rs2 == rd_q) || (exmem_reg_write && in_rs2 == exmem_rd));
   assign hazard     = in_valid && (dep1 || dep2);
   assign unused_fwd = ^{memwb_rd, memwb_reg_write, exmem_result, memwb_result, rs1_q, rs2_q};
`endif
   assign inputA         = srcA_q == SRC_RS1 ? rs1_fwd : srcA_q == SRC_PC ? pc_q : '0;
   assign inputB         = srcB_q == SRC_IMM ? imm_q : rs2_fwd;
   assign out_store_data = rs2_fwd;
   // Next state: flush squashes, advance captures or inserts a bubble, hold refreshes forwarded operands
   always_comb begin
      valid_d     = valid_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      rd_d        = rd_q;
      rs1_data_d  = rs1_data_q;
      rs2_data_d  = rs2_data_q;
      imm_d       = imm_q;
      pc_d        = pc_q;
      alu_op_d    = alu_op_q;
      srcA_d      = srcA_q;
      srcB_d      = srcB_q;
      reg_write_d = reg_write_q;
      mem_read_d  = mem_read_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (advance) begin
         valid_d = in_valid && !hazard;
         if (in_valid && !hazard) begin
            rs1_d       = in_rs1;
            rs2_d       = in_rs2;
            rd_d        = in_rd;
            rs1_data_d  = in_rs1_data;
            rs2_data_d  = in_rs2_data;
            imm_d       = in_imm;
            pc_d        = in_pc;
            alu_op_d    = in_alu_op;
            srcA_d      = in_srcA_sel;
            srcB_d      = in_srcB_sel;
            reg_write_d = in_reg_write;
            mem_read_d  = in_mem_read;
         end
      end else begin
         rs1_data_d = rs1_fwd;
         rs2_data_d = rs2_fwd;
      end
   end
   // Stage registers, cleared asynchronously so a reset drops the held instruction at once
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         valid_q     <= 1'b0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_q        <= '0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         imm_q       <= '0;
         pc_q        <= '0;
         alu_op_q    <= '0;
         srcA_q      <= '0;
         srcB_q      <= 1'b0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         rd_q        <= rd_d;
         rs1_data_q  <= rs1_data_d;
         rs2_data_q  <= rs2_data_d;
         imm_q       <= imm_d;
         pc_q        <= pc_d;
         alu_op_q    <= alu_op_d;
         srcA_q      <= srcA_d;
         srcB_q      <= srcB_d;
         reg_write_q <= reg_write_d;
         mem_read_q  <= mem_read_d;
      end
   end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenarios plus random traffic checked against a behavioural model of the stage
module tb_id_ex_stage;
   logic        clk = 1'b0;
   logic        nRst;
   logic        in_valid, in_ready;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
   logic [3:0]  in_alu_op;
   logic [1:0]  in_srcA_sel;
   logic        in_srcB_sel, in_reg_write, in_mem_read, flush, ex_ready;
   logic [4:0]  exmem_rd, memwb_rd;
   logic        exmem_reg_write, memwb_reg_write;
   logic [31:0] exmem_result, memwb_result;
   logic        out_valid;
   logic [31:0] inputA, inputB, out_store_data;
   logic [3:0]  ALUOp;
   logic [4:0]  out_rd;
   logic        out_reg_write, out_mem_read;
   int          checks = 0;
   int          failures = 0;
   typedef struct packed {
      logic        v;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] a, b, imm, pc;
      logic [3:0]  op;
      logic [1:0]  sa;
      logic        sb, rw, mr;
   } held_t;
   held_t m;
   id_ex_stage dut (
      .clk(clk), .nRst(nRst), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_pc(in_pc),
      .in_alu_op(in_alu_op), .in_srcA_sel(in_srcA_sel), .in_srcB_sel(in_srcB_sel),
      .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .flush(flush), .ex_ready(ex_ready),
      .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
      .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
      .out_valid(out_valid), .inputA(inputA), .inputB(inputB), .ALUOp(ALUOp), .out_rd(out_rd),
      .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_store_data(out_store_data)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask
   // Architectural value of register rs as seen in EX: newest in-flight result, else the given value
   function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] regv);
      logic [31:0] r;
      r = regv;
`ifdef ID_EX_FORWARD_EN
      if (rs != 0 && memwb_reg_write && memwb_rd == rs) r = memwb_result;
      if (rs != 0 && exmem_reg_write && exmem_rd == rs) r = exmem_result;
`endif
      return r;
   endfunction
   function automatic logic pending(input logic [4:0] rs);
      return rs != 0 && ((m.v && m.rw && rs == m.rd) || (exmem_reg_write && rs == exmem_rd));
   endfunction
   function automatic logic stall();
`ifdef ID_EX_FORWARD_EN
      return m.v && m.mr && m.rd != 0 && in_valid && (in_rs1 == m.rd || in_rs2 == m.rd);
`else
      return in_valid && (pending(in_rs1) || pending(in_rs2));
`endif
   endfunction
   function automatic logic [31:0] exp_a();
      return m.sa == 2'd0 ? fwd(m.rs1, m.a) : m.sa == 2'd1 ? m.pc : 32'd0;
   endfunction
   task automatic check_all();
      chk("valid", out_valid, m.v);
      chk("ready", in_ready, !stall() && (!m.v || ex_ready));
      chk("inputA", inputA, exp_a());
      chk("inputB", inputB, m.sb ? m.imm : fwd(m.rs2, m.b));
      chk("store", out_store_data, fwd(m.rs2, m.b));
      chk("aluop", ALUOp, m.op);
      chk("rd", out_rd, m.rd);
      chk("regwrite", out_reg_write, m.v & m.rw);
      chk("memread", out_mem_read, m.v & m.mr);
   endtask
   task automatic model_next();
      logic take;
      take = in_valid && !stall() && (!m.v || ex_ready);
      if (flush) m.v = 1'b0;
      else if (!m.v || ex_ready) begin
         m.v = take;
         if (take) begin
            m.rs1 = in_rs1; m.rs2 = in_rs2; m.rd = in_rd; m.a = in_rs1_data; m.b = in_rs2_data;
            m.imm = in_imm; m.pc = in_pc; m.op = in_alu_op; m.sa = in_srcA_sel; m.sb = in_srcB_sel;
            m.rw = in_reg_write; m.mr = in_mem_read;
         end
      end else begin
         m.a = fwd(m.rs1, m.a);
         m.b = fwd(m.rs2, m.b);
      end
   endtask
   task automatic step();
      @(negedge clk);
      check_all();
      model_next();
      @(posedge clk);
      #1;
   endtask
   task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [1:0] sa,
                        input logic sb, input logic rw, input logic mr);
      in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rs1_data = d1; in_rs2_data = d2;
      in_srcA_sel = sa; in_srcB_sel = sb; in_reg_write = rw; in_mem_read = mr;
   endtask
   initial begin
      logic [31:0] fwd_aa, hold_b;
`ifdef ID_EX_FORWARD_EN
      fwd_aa = 32'hAA; hold_b = 32'h55;
`else
      fwd_aa = 32'h11; hold_b = 32'h12;
`endif
      nRst = 1'b0; m = '0;
      in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rs1_data = 0; in_rs2_data = 0;
      in_imm = 0; in_pc = 0; in_alu_op = 0; in_srcA_sel = 0; in_srcB_sel = 0;
      in_reg_write = 0; in_mem_read = 0; flush = 0; ex_ready = 1;
      exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0; memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0;
      #12;
      chk("rst_valid", out_valid, 0);
      @(negedge clk) nRst = 1'b1;
      @(posedge clk); #1;
      chk("rst_ready", in_ready, 1);
      check_all();
      // ADDI: A from rs1 data, B from immediate
      instr(5'd1, 5'd0, 5'd2, 32'd5, 32'd0, 2'd0, 1'b1, 1'b1, 1'b0);
      in_imm = 32'd7; in_alu_op = 4'h3; in_pc = 32'h100;
      step();
      in_valid = 1'b0;
      #1;
      chk("addi_valid", out_valid, 1);
      chk("addi_a", inputA, 32'd5);
      chk("addi_b", inputB, 32'd7);
      chk("addi_op", ALUOp, 4'h3);
      // Forward priority on rs1=3, then rd=0 producers are ignored
      instr(5'd3, 5'd0, 5'd5, 32'h11, 32'h0, 2'd0, 1'b1, 1'b1, 1'b0);
      step();
      in_valid = 1'b0;
      exmem_rd = 5'd3; exmem_reg_write = 1'b1; exmem_result = 32'hAA;
      memwb_rd = 5'd3; memwb_reg_write = 1'b1; memwb_result = 32'hBB;
      #1 chk("fwd_prio", inputA, fwd_aa);
      exmem_rd = 5'd0; memwb_rd = 5'd0;
      #1 chk("fwd_x0", inputA, 32'h11);
      step();
      exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;
      // Load-use: lw x4 then a consumer of x4 via rs2
      instr(5'd1, 5'd0, 5'd4, 32'h0, 32'h0, 2'd0, 1'b1, 1'b1, 1'b1);
      step();
      instr(5'd1, 5'd4, 5'd7, 32'h9, 32'h4, 2'd0, 1'b0, 1'b1, 1'b0);
      #1 chk("lu_ready", in_ready, 0);
      step();
      chk("lu_bubble", out_valid, 0);
      chk("lu_ready2", in_ready, 1);
      step();
      chk("lu_accept", out_valid, 1);
      chk("lu_rd", out_rd, 5'd7);
      // Hold with MEM/WB forwarding, then MEM/WB retires
      instr(5'd0, 5'd6, 5'd8, 32'h0, 32'h12, 2'd2, 1'b0, 1'b1, 1'b0);
      step();
      in_valid = 1'b0; ex_ready = 1'b0;
      memwb_rd = 5'd6; memwb_reg_write = 1'b1; memwb_result = 32'h55;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_b", inputB, hold_b);
         chk("hold_v", out_valid, 1);
      end
      memwb_reg_write = 1'b0; memwb_result = 32'h0;
      step();
      chk("hold_retired", inputB, hold_b);
      chk("hold_rd", out_rd, 5'd8);
      ex_ready = 1'b1;
      // Flush beats a same-cycle capture
      instr(5'd0, 5'd0, 5'd9, 32'h1, 32'h2, 2'd0, 1'b0, 1'b1, 1'b0);
      flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_v", out_valid, 0);
      chk("flush_rw", out_reg_write, 0);
      // Reset asserted while stalled
      instr(5'd2, 5'd3, 5'd10, 32'h77, 32'h88, 2'd0, 1'b0, 1'b1, 1'b1);
      step();
      in_valid = 1'b0; ex_ready = 1'b0;
      step();
      step();
      #2 nRst = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_rw", out_reg_write, 0);
      m = '0;
      @(negedge clk) nRst = 1'b1;
      ex_ready = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_ready", in_ready, 1);
      chk("post_rst_a", inputA, 0);
      chk("post_rst_b", inputB, 0);
      chk("post_rst_store", out_store_data, 0);
      chk("post_rst_op", ALUOp, 0);
      chk("post_rst_rd", out_rd, 0);
      // Random traffic on a small register window to provoke matches
      for (int n = 0; n < 400; n++) begin
         in_valid = $urandom_range(0, 9) < 7;
         in_rs1 = 5'($urandom_range(0, 3)); in_rs2 = 5'($urandom_range(0, 3)); in_rd = 5'($urandom_range(0, 3));
         in_rs1_data = $urandom; in_rs2_data = $urandom; in_imm = $urandom; in_pc = $urandom;
         in_alu_op = 4'($urandom); in_srcA_sel = 2'($urandom); in_srcB_sel = 1'($urandom);
         in_reg_write = 1'($urandom); in_mem_read = $urandom_range(0, 2) == 0;
         flush = $urandom_range(0, 9) == 0; ex_ready = $urandom_range(0, 9) < 7;
         exmem_rd = 5'($urandom_range(0, 3)); exmem_reg_write = 1'($urandom); exmem_result = $urandom;
         memwb_rd = 5'($urandom_range(0, 3)); memwb_reg_write = 1'($urandom); memwb_result = $urandom;
         step();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
